// File: rtl/delay_line_var.sv
// ---------------------------------------------------------------------------
// delay_line_var
//
// Variable-length sample delay line for datapath alignment (e.g. channel skew
// matching). Delays a WIDTH-bit stream by 0..MAX_DELAY enabled cycles, where
// the delay is selected at runtime and may change on any cycle.
//
// Parameters:
//   WIDTH      data bits per sample (>= 1)
//   MAX_DELAY  deepest selectable delay, equal to the number of storage stages (>= 1)
//   DELAY_W    width of data_delay_i, derived from MAX_DELAY (not overridable)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset; clears taps and fill count
//   en_i          shift enable; the line advances only on enabled edges
//   data_i        input sample
//   data_delay_i  requested delay in enabled cycles
//   data_o        delayed sample (data_i itself when the effective delay is 0)
//   valid_o       1 when data_o holds real history for the effective delay
//   dly_clamp_o   1 when data_delay_i exceeds MAX_DELAY (always combinational)
//
// Build option:
//   DELAY_LINE_VAR_OREG_EN  when defined, data_o and valid_o are registered.
//                           That adds one clock of latency. The register updates
//                           on every edge, independent of en_i.
// ---------------------------------------------------------------------------
module delay_line_var #(
    parameter int WIDTH     = 1,
    parameter int MAX_DELAY = 15,
    localparam int DELAY_W  = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [DELAY_W-1:0] data_delay_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    output logic               dly_clamp_o
);

    localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

    logic [WIDTH-1:0]   tap_q [MAX_DELAY];
    logic [WIDTH-1:0]   tap_d [MAX_DELAY];
    logic [DELAY_W-1:0] fill_q;
    logic [DELAY_W-1:0] fill_d;

    logic [DELAY_W-1:0] eff_d;
    logic               clamp;
    logic [WIDTH-1:0]   tap_sel;
    logic [WIDTH-1:0]   mux_data;
    logic               mux_valid;

    // ------------------------------------------------------------------
    // Shift register: advances only on enabled edges.
    // ------------------------------------------------------------------
    always_comb begin
        tap_d = tap_q;
        if (en_i) begin
            tap_d[0] = data_i;
            for (int k = 1; k < MAX_DELAY; k++) begin
                tap_d[k] = tap_q[k-1];
            end
        end
    end

    // Fill count saturates at MAX_DELAY. Once it saturates, every tap holds history.
    always_comb begin
        fill_d = fill_q;
        if (en_i && (fill_q != MAX_D)) begin
            fill_d = fill_q + DELAY_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                tap_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            tap_q  <= tap_d;
            fill_q <= fill_d;
        end
    end

    // ------------------------------------------------------------------
    // Delay select. An out-of-range request is clamped to the deepest tap.
    // The clamp can only be reached when MAX_DELAY+1 is not a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        clamp = (data_delay_i > MAX_D);
        eff_d = clamp ? MAX_D : data_delay_i;
    end

    assign dly_clamp_o = clamp;

    // A one-hot compare per tap keeps the index in range for any eff_d.
    always_comb begin
        tap_sel = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (eff_d == DELAY_W'(k + 1)) begin
                tap_sel = tap_q[k];
            end
        end
    end

    // A delay of zero is a zero-latency passthrough and is always valid,
    // even while reset is asserted.
    always_comb begin
        mux_data  = (eff_d == '0) ? data_i : tap_sel;
        mux_valid = (fill_q >= eff_d);
    end

`ifdef DELAY_LINE_VAR_OREG_EN
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
        data_d  = mux_data;
        valid_d = mux_valid;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`else
    assign data_o  = mux_data;
    assign valid_o = mux_valid;
`endif

endmodule

// File: tb/tb_delay_line_var.sv
module tb_delay_line_var;

    logic       clk_i;
    logic       rst_i;
    logic       en_i;
    logic [7:0] data_i;
    logic [3:0] dly_i;

    logic [7:0] data15;
    logic       valid15;
    logic       clamp15;
    logic [7:0] data12;
    logic       valid12;
    logic       clamp12;

    int total = 0;
    int bad   = 0;

    // Reference model: every sample accepted on an enabled edge since the last
    // reset, in order. The sample delayed by d edges is hist[n-d].
    logic [7:0] hist [0:8191];
    int         n = 0;

    delay_line_var #(.WIDTH(8), .MAX_DELAY(15)) u_dut15 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_delay_i (dly_i),
        .data_o       (data15),
        .valid_o      (valid15),
        .dly_clamp_o  (clamp15)
    );

    delay_line_var #(.WIDTH(8), .MAX_DELAY(12)) u_dut12 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_delay_i (dly_i),
        .data_o       (data12),
        .valid_o      (valid12),
        .dly_clamp_o  (clamp12)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff(int m);
        return (int'(dly_i) > m) ? m : int'(dly_i);
    endfunction

    function automatic logic [7:0] exp_data(int m);
        int e;
        e = eff(m);
        if (e == 0) return data_i;
        if (n >= e) return hist[n-e];
        return 8'h00;
    endfunction

    function automatic logic exp_valid(int m);
        int e;
        e = eff(m);
        return (e == 0) || (n >= e);
    endfunction

    task automatic check_all();
        chk("d15_data",  32'(data15),  32'(exp_data(15)));
        chk("d15_valid", 32'(valid15), 32'(exp_valid(15)));
        chk("d15_clamp", 32'(clamp15), 32'(int'(dly_i) > 15));
        chk("d12_data",  32'(data12),  32'(exp_data(12)));
        chk("d12_valid", 32'(valid12), 32'(exp_valid(12)));
        chk("d12_clamp", 32'(clamp12), 32'(int'(dly_i) > 12));
    endtask

    // Called 1 time unit after a rising edge: apply inputs and check combinational outputs.
    task automatic drive(input logic en, input logic [7:0] d, input logic [3:0] dly);
        en_i   = en;
        data_i = d;
        dly_i  = dly;
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (en_i && !rst_i) begin
            hist[n] = data_i;
            n++;
        end
        #1;
    endtask

    // Assert reset between edges, check outputs while it is asserted, then release it.
    task automatic async_reset();
        rst_i = 1'b1;
        n     = 0;
        #1;
        check_all();
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0] held_d;
        logic       held_v;
        int         edges;

        rst_i  = 1'b1;
        en_i   = 1'b0;
        data_i = 8'hA5;
        dly_i  = 4'd0;
        @(posedge clk_i);
        #1;

        // Passthrough while reset is asserted: no edge is needed.
        drive(1'b0, 8'hA5, 4'd0);
        chk("pt_data",  32'(data15),  32'h A5);
        chk("pt_valid", 32'(valid15), 32'd1);
        drive(1'b1, 8'h3C, 4'd5);
        chk("rst_data",  32'(data15),  32'd0);
        chk("rst_valid", 32'(valid15), 32'd0);
        tick();
        rst_i = 1'b0;

        // Fill at delay 5 with data 1, 2, 3, ...
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i + 1), 4'd5);
            if (i == 4) chk("fill_c4_valid", 32'(valid15), 32'd0);
            if (i == 5) begin
                chk("fill_c5_valid", 32'(valid15), 32'd1);
                chk("fill_c5_data",  32'(data15),  32'd1);
            end
            if (i == 6) chk("fill_c6_data", 32'(data15), 32'd2);
            tick();
        end

        // Stall at delay 3 on a full line.
        drive(1'b1, 8'h50, 4'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'($urandom), 4'd3);
            if (i == 0) begin
                held_d = data15;
                held_v = valid15;
            end else begin
                chk("stall_hold_d", 32'(data15),  32'(held_d));
                chk("stall_hold_v", 32'(valid15), 32'(held_v));
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'($urandom), 4'd3);
            tick();
        end

        // 20 cycles at delay 2, then jump to 15 and then to 14 (14 is clamped on the 12-deep line).
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom), 4'd2);
            tick();
        end
        drive(1'b1, 8'($urandom), 4'd15);
        chk("jump15_valid", 32'(valid15), 32'd1);
        tick();
        drive(1'b1, 8'($urandom), 4'd14);
        chk("clamp12", 32'(clamp12), 32'd1);
        tick();

        // Reset, 4 enabled cycles at delay 2, then switch to 10.
        async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'($urandom), 4'd2);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom), 4'd10);
            tick();
        end

        // Mid-stream reset at delay 7; valid_o returns after seven enabled edges.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'($urandom), 4'd7);
            tick();
        end
        async_reset();
        chk("mid_rst_data",  32'(data15),  32'd0);
        chk("mid_rst_valid", 32'(valid15), 32'd0);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom), 4'd7);
            if (valid15) break;
            tick();
            edges++;
        end
        tick();
        chk("refill_edges", 32'(edges), 32'd7);

        // Random enables, data, delays and occasional resets.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 15)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
Parametrised variable-length delay line, successor to the fixed 1-bit/15-tap delay block. It delays a WIDTH-bit sample stream by a runtime-selectable 0..MAX_DELAY enabled cycles. A shift-enable input stalls the line. A fill counter drives valid_o, which reports whether the selected tap holds real history. The block sits in datapath alignment paths, e.g. skew matching between channels.

Parameters:
WIDTH, 1, data bits per sample (>=1)
MAX_DELAY, 15, deepest selectable delay in enabled cycles (>=1); number of storage stages
DELAY_W, $clog2(MAX_DELAY+1), width of data_delay_i; localparam, not user-overridable

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
en_i  input  1  shift enable; line advances only on edges where en_i=1
data_i  input  WIDTH  input sample
data_delay_i  input  DELAY_W  requested delay in enabled cycles; may change any cycle
data_o  output  WIDTH  delayed sample
valid_o  output  1  1 when data_o is real history for the effective delay
dly_clamp_o  output  1  1 when data_delay_i > MAX_DELAY (combinational)

Behaviour:
- Storage: tap[0..MAX_DELAY-1], WIDTH bits each. On a rising edge with en_i=1: tap[0]<=data_i and tap[k]<=tap[k-1]. With en_i=0 all taps hold.
- Effective delay eff_d = min(data_delay_i, MAX_DELAY). dly_clamp_o = (data_delay_i > MAX_DELAY). It can only assert when MAX_DELAY+1 is not a power of 2.
- Output mux is combinational: eff_d=0 -> data_o=data_i (pure passthrough, zero latency); eff_d=d>0 -> data_o=tap[d-1].
- With en_i held at 1, data_o(t) = data_i(t-d). With stalls, the delay counts enabled edges only.
- fill_cnt: width DELAY_W, reset 0. It increments on each enabled edge and saturates at MAX_DELAY. It never decrements except on reset.
- valid_o = (fill_cnt >= eff_d), combinational. eff_d=0 -> valid_o=1 always, including in reset.
- Delay change: takes effect in the same cycle, with no settling wait. A new delay <= fill_cnt is valid immediately. A larger delay gives valid_o=0 until fill_cnt catches up. No glitch suppression is done; the mux simply selects the new tap.
- Reset (asynchronous, any time, including mid-stream): all taps=0, fill_cnt=0. During reset and immediately after, for eff_d>0: data_o=0 and valid_o=0. History is lost, so refill is required after reset.
- Simultaneous en_i=1 and delay change on one edge: the shift and the count update normally. Output for the following cycle uses the new tap and the updated fill_cnt.
- No X propagation: every register has a reset value.

Optional Feature:
Macro DELAY_LINE_VAR_OREG_EN.
- Defined: data_o and valid_o come from an output register, reset 0. The register updates on every clock edge, independent of en_i.
- Total latency is eff_d enabled cycles plus 1 clock. eff_d=0 therefore gives 1-cycle latency, with valid_o=1 from the first edge after reset release.
- dly_clamp_o stays combinational.
- Not defined: the outputs are purely combinational from the taps, as described above.

Test Plan:
- Reset then fill: WIDTH=8, MAX_DELAY=15, en_i=1, data_delay_i=5, data_i=1,2,3,... from cycle 0. Required: valid_o=0 for cycles 0-4; at cycle 5 valid_o=1 and data_o=1; at cycle 6 data_o=2.
- Passthrough: data_delay_i=0, data_i=8'hA5 during rst_i=1. Required: data_o=8'hA5 and valid_o=1 in the same cycle, with no clock edge needed.
- Stall: delay 3, full line, en_i=0 for 4 cycles. Required: data_o and valid_o frozen; after en_i returns to 1, the output sequence resumes with no sample skipped or duplicated.
- Delay change: after 20 enabled cycles at delay 2, switch to 15. Required: valid_o stays 1 and data_o=data_i(t-15) on the same cycle. After a reset plus 4 enabled cycles, switch from 2 to 10. Required: valid_o=0 until fill_cnt=10.
- Clamp: MAX_DELAY=12, data_delay_i=14. Required: dly_clamp_o=1 and data_o=data_i(t-12).
- Mid-stream reset: assert rst_i asynchronously between edges at delay 7. Required: data_o=0 and valid_o=0 immediately; valid_o first returns to 1 seven enabled edges after release. Check random delays and data over 1000 cycles against a history-array model.
